// File: rtl/z_sqcsa_pkg.sv
// Package: z_sqcsa_pkg -- geometry helpers for the pipelined square-root carry-select adder.
// Block j is j+2 bits wide and starts at bit blk_off(j); group g spans blocks [g*bps, grp_end).
package z_sqcsa_pkg;

   function automatic int sqcsa_width(input int k);
      return k * (k + 3) / 2;
   endfunction

   function automatic int blk_off(input int j);
      return j * (j + 3) / 2;
   endfunction

   function automatic int num_stages(input int k, input int bps);
      return (k + bps - 1) / bps;
   endfunction

   function automatic int grp_end(input int k, input int bps, input int g);
      return ((g + 1) * bps < k) ? (g + 1) * bps : k;
   endfunction

endpackage

// File: rtl/z_sqcsa_pipe_blk.sv
// Module: z_csa_blk -- one carry-select block: two ripple adders (carry 0 / carry 1)
// and a late select on the incoming block carry.
module z_csa_blk #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W-1:0] s0, s1;
   logic [W:0]   c0, c1;

   always_comb begin
      s0    = '0;
      s1    = '0;
      c0    = '0;
      c1    = '0;
      c1[0] = 1'b1;
      for (int i = 0; i < W; i++) begin
         s0[i]   = a[i] ^ b[i] ^ c0[i];
         s1[i]   = a[i] ^ b[i] ^ c1[i];
         c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
         c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
      end
   end

   assign s    = cin ? s1 : s0;
   assign cout = cin ? c1[W] : c0[W];

endmodule

// File: rtl/z_sqcsa_pipe.sv
// Module: z_sqcsa_pipe -- pipelined SQCSA, sum = a + b + c_in, with stall-all valid/ready.
// Define ZSQCSA_OVF_EN to build the registered signed-overflow flag; otherwise ovf is tied low.
module z_sqcsa_pipe
   import z_sqcsa_pkg::*;
#(
   parameter int K           = 15,
   parameter int BLK_PER_STG = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [sqcsa_width(K)-1:0] a,
   input  logic [sqcsa_width(K)-1:0] b,
   input  logic                      c_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [sqcsa_width(K)-1:0] sum,
   output logic                      c_out,
   output logic                      ovf
);

   localparam int N = sqcsa_width(K);
   localparam int L = num_stages(K, BLK_PER_STG);

   logic         adv;
   logic [L:1]   vld_q;
   logic [L:0]   vld_chain;
   logic [N-1:0] fin_sum;
   logic         fin_cout;

   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign vld_chain = {vld_q, in_valid};
   assign out_valid = vld_q[L];

   // All stages move together, so bubbles and ordering are preserved for free.
   always_ff @(posedge clk) begin
      if (rst)
         vld_q <= '0;
      else if (adv)
         vld_q <= vld_chain[L-1:0];
   end

   for (genvar g = 0; g < L; g++) begin : grp
      localparam int BS = g * BLK_PER_STG;
      localparam int BE = grp_end(K, BLK_PER_STG, g);
      localparam int LO = blk_off(BS);
      localparam int HI = blk_off(BE);

      logic [N-LO-1:0]  ha, hb;
      logic [BE-BS:0]   cy;
      logic [HI-LO-1:0] gsum;
      logic [HI-1:0]    nxt_sum;
      logic             gcout;

      assign gcout = cy[BE-BS];

      for (genvar j = BS; j < BE; j++) begin : blk
         localparam int OB = blk_off(j) - LO;
         if (j == 0) begin : rip
            assign {cy[1], gsum[1:0]} = {1'b0, ha[1:0]} + {1'b0, hb[1:0]} + {2'b00, cy[0]};
         end else begin : sel
            z_csa_blk #(.W(j + 2)) u_blk (
               .a    (ha[OB+j+1:OB]),
               .b    (hb[OB+j+1:OB]),
               .cin  (cy[j-BS]),
               .s    (gsum[OB+j+1:OB]),
               .cout (cy[j-BS+1])
            );
         end
      end

      if (g == 0) begin : st
         assign ha      = a;
         assign hb      = b;
         assign cy[0]   = c_in;
         assign nxt_sum = gsum;
      end else begin : st
         localparam int PLO = blk_off((g - 1) * BLK_PER_STG);
         logic [LO-1:0]   lo_q;
         logic [N-LO-1:0] a_q, b_q;
         logic            c_q;

         // Operand skew: only bits not yet consumed by earlier groups travel forward.
         always_ff @(posedge clk) begin
            if (adv) begin
               lo_q <= grp[g-1].nxt_sum;
               a_q  <= grp[g-1].ha[N-PLO-1:LO-PLO];
               b_q  <= grp[g-1].hb[N-PLO-1:LO-PLO];
               c_q  <= grp[g-1].gcout;
            end
         end

         assign ha      = a_q;
         assign hb      = b_q;
         assign cy[0]   = c_q;
         assign nxt_sum = {gsum, lo_q};
      end
   end

   assign fin_sum  = grp[L-1].nxt_sum;
   assign fin_cout = grp[L-1].gcout;

   // Output stage only loads real results, so bubbles never disturb the held sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum   <= '0;
         c_out <= 1'b0;
      end else if (adv && vld_chain[L-1]) begin
         sum   <= fin_sum;
         c_out <= fin_cout;
      end
   end

`ifdef ZSQCSA_OVF_EN
   localparam int LOL = blk_off((L - 1) * BLK_PER_STG);
   logic fin_cin_msb;

   // Carry into the MSB is recovered from the MSB sum and operand bits.
   assign fin_cin_msb = fin_sum[N-1] ^ grp[L-1].ha[N-LOL-1] ^ grp[L-1].hb[N-LOL-1];

   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (adv && vld_chain[L-1])
         ovf <= fin_cin_msb ^ fin_cout;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_z_sqcsa_pipe.sv
// Testbench: tb_z_sqcsa_pipe -- directed vector table, pipeline corner sequences and a
// randomized stream, all scored against a plain a+b+c_in model (honours ZSQCSA_OVF_EN).
module tb_z_sqcsa_pipe;

   localparam int N = 135;
   localparam int L = 4;

   typedef logic [N:0] wide_t;
   typedef struct packed {
      logic [N-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;
   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         cin;
      logic [N-1:0] sum;
      logic         cout;
      logic         ovf_s;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
   logic [N-1:0] a, b, sum;

   int   tests = 0;
   int   fails = 0;
   int   run_len = 0;
   int   max_run = 0;
   logic rand_bp = 1'b0;
   res_t exp_q[$];
   res_t sb_head;
   vec_t vecs[10];

   z_sqcsa_pipe #(.K(15), .BLK_PER_STG(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic ovfExpect(input logic signed_ovf);
`ifdef ZSQCSA_OVF_EN
      return signed_ovf;
`else
      return 1'b0;
`endif
   endfunction

   function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
      res_t       r;
      logic [N:0] t;
      t      = {1'b0, x} + {1'b0, y} + wide_t'(ci);
      r.sum  = t[N-1:0];
      r.cout = t[N];
      r.ovf  = ovfExpect((x[N-1] == y[N-1]) && (t[N-1] != x[N-1]));
      return r;
   endfunction

   function automatic logic [N-1:0] randOp();
      logic [N-1:0] r;
      r = '0;
      case ($urandom_range(0, 5))
         0: r = '1;
         1: r = N'($urandom_range(0, 15));
         default: for (int i = 0; i < 5; i++) r = (r << 32) | N'($urandom);
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
      logic acc;
      int   guard;
      a        = av;
      b        = bv;
      c_in     = cv;
      in_valid = 1'b1;
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 50) begin
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) checkOutput("accept_timeout", wide_t'(in_ready), wide_t'(1));
      in_valid = 1'b0;
   endtask

   task automatic idleCycle();
      in_valid = 1'b0;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("drain", wide_t'(exp_q.size()), '0);
   endtask

   task automatic setVec(input int i, input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                         input logic [N-1:0] sv, input logic co, input logic ov);
      vecs[i].a     = av;
      vecs[i].b     = bv;
      vecs[i].cin   = cv;
      vecs[i].sum   = sv;
      vecs[i].cout  = co;
      vecs[i].ovf_s = ov;
   endtask

   // Scoreboard: queue model results on accepted inputs, compare on every accepted output.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         run_len = 0;
      end else begin
         if (out_valid && out_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_out", wide_t'(out_valid), '0);
            end else begin
               sb_head = exp_q.pop_front();
               checkOutput("sb_result", {c_out, sum}, {sb_head.cout, sb_head.sum});
               checkOutput("sb_ovf", wide_t'(ovf), wide_t'(sb_head.ovf));
            end
         end else begin
            run_len = 0;
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in));
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [N-1:0] ones, one, msb, alt;
      logic [N-1:0] sa[4], sb[4];
      logic         sc[4];
      res_t         held;
      int           lat;

      ones = '1;
      one  = N'(1);
      msb  = '0;
      msb[N-1] = 1'b1;
      alt  = '0;
      for (int i = 0; i < N; i += 2) alt[i] = 1'b1;

      setVec(0, ones, ones, 1'b1, ones, 1'b1, 1'b0);
      setVec(1, one, ones, 1'b0, '0, 1'b1, 1'b0);
      setVec(2, msb, msb, 1'b0, '0, 1'b1, 1'b1);
      setVec(3, '0, '0, 1'b0, '0, 1'b0, 1'b0);
      setVec(4, '0, '0, 1'b1, one, 1'b0, 1'b0);
      setVec(5, ones >> 1, one, 1'b0, msb, 1'b0, 1'b1);
      setVec(6, alt, ~alt, 1'b1, '0, 1'b1, 1'b0);
      setVec(7, (one << 14) - one, '0, 1'b1, one << 14, 1'b0, 1'b0);
      setVec(8, (one << 44) - one, '0, 1'b1, one << 44, 1'b0, 1'b0);
      setVec(9, (one << 90) - one, one, 1'b0, one << 90, 1'b0, 1'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_out_valid", wide_t'(out_valid), '0);
      checkOutput("reset_result", {c_out, sum}, '0);
      checkOutput("reset_ovf", wide_t'(ovf), '0);
      checkOutput("reset_in_ready", wide_t'(in_ready), wide_t'(1));

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         checkOutput($sformatf("vec%0d_latency", i), wide_t'(lat), wide_t'(L - 1));
         checkOutput($sformatf("vec%0d_result", i), {c_out, sum}, {vecs[i].cout, vecs[i].sum});
         checkOutput($sformatf("vec%0d_ovf", i), wide_t'(ovf), wide_t'(ovfExpect(vecs[i].ovf_s)));
         @(posedge clk);
         #1;
      end
      waitDrain();

      max_run = 0;
      run_len = 0;
      for (int i = 0; i < 10; i++) applyStimulus(N'(i), N'(3 * i), i[0]);
      waitDrain();
      checkOutput("b2b_consecutive", wide_t'(max_run), wide_t'(10));

      for (int i = 0; i < 4; i++) begin
         sa[i] = randOp();
         sb[i] = randOp();
         sc[i] = 1'($urandom_range(0, 1));
      end
      held = model(sa[0], sb[0], sc[0]);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(sa[i], sb[i], sc[i]);
      a        = randOp();
      b        = randOp();
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checkOutput("stall_in_ready", wide_t'(in_ready), '0);
         checkOutput("stall_out_valid", wide_t'(out_valid), wide_t'(1));
         checkOutput("stall_hold", {c_out, sum}, {held.cout, held.sum});
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain();

      for (int i = 0; i < 3; i++) applyStimulus(randOp() | one, randOp(), 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst_out_valid", wide_t'(out_valid), '0);
      checkOutput("midrst_result", {c_out, sum}, '0);
      checkOutput("midrst_ovf", wide_t'(ovf), '0);
      checkOutput("midrst_in_ready", wide_t'(in_ready), wide_t'(1));
      repeat (8) idleCycle();
      checkOutput("midrst_no_stale", wide_t'(out_valid), '0);

      rand_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(randOp(), randOp(), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idleCycle();
      end
      rand_bp   = 1'b0;
      out_ready = 1'b1;
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
